// File: rtl/park_pkg.sv
// ---------------------------------------------------------------------------
// park_pkg
//   Shared definitions for the parking-lot control blocks.
//   - gate_state_e : entry-gate FSM state encoding. The encoding is visible
//                    externally on state_dbg, so the values are fixed.
//   - MAX_SPACES   : capacity of the lot, shared with the space counter.
//   - max3()       : elaboration-time helper for sizing shared timers.
// ---------------------------------------------------------------------------
package park_pkg;

   typedef enum logic [2:0] {
      ST_IDLE        = 3'd0,
      ST_WAIT_TICKET = 3'd1,
      ST_OPEN        = 3'd2,
      ST_PASSING     = 3'd3,
      ST_CLOSE_HOLD  = 3'd4,
      ST_DENIED      = 3'd5
   } gate_state_e;

   localparam int MAX_SPACES = 64;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage : park_pkg

// File: rtl/sync_edge.sv
// ---------------------------------------------------------------------------
// sync_edge
//   Two-flop synchronizer for one asynchronous level input, followed by a
//   one-cycle delayed copy so that single-cycle rise/fall strobes can be
//   derived in the clk domain.
// Ports
//   clk      in   clock
//   reset    in   synchronous, active-high; clears all three flops
//   async_i  in   asynchronous level input
//   sync_o   out  synchronized level (2 cycles after the async change)
//   rise_o   out  1-cycle strobe when sync_o goes 0 -> 1
//   fall_o   out  1-cycle strobe when sync_o goes 1 -> 0
// ---------------------------------------------------------------------------
module sync_edge
   import park_pkg::*;
(
   input  logic clk,
   input  logic reset,
   input  logic async_i,
   output logic sync_o,
   output logic rise_o,
   output logic fall_o
);

   logic meta_q;
   logic sync_q;
   logic dly_q;

   // NOTE: meta_q may go metastable; nothing but sync_q may ever read it.
   always_ff @(posedge clk) begin
      if (reset) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
         dly_q  <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments make the three flops shift as one
         // chain; blocking ones would collapse them into a single stage.
         meta_q <= async_i;
         sync_q <= meta_q;
         dly_q  <= sync_q;
      end
   end

   assign sync_o = sync_q;
   assign rise_o = sync_q & ~dly_q;
   assign fall_o = ~sync_q & dly_q;

endmodule : sync_edge

// File: rtl/entry_gate_ctrl.sv
// ---------------------------------------------------------------------------
// entry_gate_ctrl
//   Entry-barrier controller for the normal-parking lane. Sequences the
//   approach loop, ticket button and pass-through loop; opens the barrier
//   only when the space counter reports a free space at the ticket press.
//   After a car has fully cleared the barrier it emits a fixed-length
//   entry_pulse for the downstream space counter.
// Parameters
//   OPEN_TIMEOUT  cycles the barrier waits open for the pass loop (>=2)
//   CLOSE_HOLD    cycles the barrier is held open after the car clears
//                 (>=PULSE_LEN)
//   DENY_CYCLES   cycles full_lamp is lit after a denied request (>=1)
//   PULSE_LEN     entry_pulse width in cycles (>=1)
// Ports
//   clk, reset     clock; synchronous active-high reset
//   car_present    approach loop, async level
//   car_passed     pass loop, async level
//   ticket_req     ticket button, async level (debounced externally)
//   space_avail    1 = at least one free space (same clock domain)
//   barrier_open   1 = drive barrier up
//   entry_pulse    high PULSE_LEN cycles per completed entry
//   full_lamp      1 while a ticket request is being denied
//   timeout_alarm  sticky; set on open timeout, cleared by next entry
//   state_dbg      current FSM state encoding
// ---------------------------------------------------------------------------
module entry_gate_ctrl
   import park_pkg::*;
#(
   parameter int OPEN_TIMEOUT = 200,
   parameter int CLOSE_HOLD   = 50,
   parameter int DENY_CYCLES  = 100,
   parameter int PULSE_LEN    = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       car_present,
   input  logic       car_passed,
   input  logic       ticket_req,
   input  logic       space_avail,
   output logic       barrier_open,
   output logic       entry_pulse,
   output logic       full_lamp,
   output logic       timeout_alarm,
   output logic [2:0] state_dbg
);

   // One down-timer is shared by OPEN, CLOSE_HOLD and DENIED; it is sized
   // for the longest of the three intervals.
   localparam int TMR_MAX = max3(OPEN_TIMEOUT, CLOSE_HOLD, DENY_CYCLES);
   localparam int TW      = $clog2(TMR_MAX);
   localparam int PCW     = (PULSE_LEN > 1) ? $clog2(PULSE_LEN) : 1;

   localparam logic [TW-1:0]  OPEN_LOAD  = TW'(OPEN_TIMEOUT - 1);
   localparam logic [TW-1:0]  HOLD_LOAD  = TW'(CLOSE_HOLD - 1);
   localparam logic [TW-1:0]  DENY_LOAD  = TW'(DENY_CYCLES - 1);
   localparam logic [PCW-1:0] PULSE_LOAD = PCW'(PULSE_LEN - 1);

   // ---------------- input synchronization ----------------
   logic present_s, present_rise, present_fall;
   logic passed_s,  passed_rise,  passed_fall;
   logic ticket_s,  ticket_rise,  ticket_fall;

   sync_edge u_sync_present (
      .clk     (clk),
      .reset   (reset),
      .async_i (car_present),
      .sync_o  (present_s),
      .rise_o  (present_rise),
      .fall_o  (present_fall)
   );

   sync_edge u_sync_passed (
      .clk     (clk),
      .reset   (reset),
      .async_i (car_passed),
      .sync_o  (passed_s),
      .rise_o  (passed_rise),
      .fall_o  (passed_fall)
   );

   sync_edge u_sync_ticket (
      .clk     (clk),
      .reset   (reset),
      .async_i (ticket_req),
      .sync_o  (ticket_s),
      .rise_o  (ticket_rise),
      .fall_o  (ticket_fall)
   );

   // Only some of the strobes are needed by the FSM.
   logic unused_sync;
   assign unused_sync = &{1'b0, present_rise, present_fall, passed_s,
                          ticket_s, ticket_fall};

   // ---------------- state ----------------
   gate_state_e    state_q, state_d;
   logic [TW-1:0]  timer_q, timer_d;
   logic           alarm_q, alarm_d;
   logic           pulse_start;
   logic [PCW-1:0] pulse_cnt_q;
   logic           entry_pulse_q;
   logic           barrier_open_q;
   logic           full_lamp_q;

   // NOTE: every variable written here gets a default first, so no path
   // leaves one unassigned and no latch is inferred.
   always_comb begin
      state_d     = state_q;
      // Decrement-only, saturating at zero.
      timer_d     = (timer_q != '0) ? timer_q - TW'(1) : timer_q;
      alarm_d     = alarm_q;
      pulse_start = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (present_s) state_d = ST_WAIT_TICKET;
         end
         ST_WAIT_TICKET: begin
            // A car backing away wins over a simultaneous ticket press.
            if (!present_s) begin
               state_d = ST_IDLE;
            end else if (ticket_rise) begin
               // space_avail matters only at this instant.
               if (space_avail) begin
                  state_d = ST_OPEN;
                  timer_d = OPEN_LOAD;
               end else begin
                  state_d = ST_DENIED;
                  timer_d = DENY_LOAD;
               end
            end
         end
         ST_DENIED: begin
            if (timer_q == '0) state_d = present_s ? ST_WAIT_TICKET : ST_IDLE;
         end
         ST_OPEN: begin
            // A car arriving on the loop wins over the timeout.
            if (passed_rise) begin
               state_d = ST_PASSING;
            end else if (timer_q == '0) begin
               state_d = ST_CLOSE_HOLD;
               timer_d = HOLD_LOAD;
               alarm_d = 1'b1;
            end
         end
         ST_PASSING: begin
            if (passed_fall) begin
               state_d     = ST_CLOSE_HOLD;
               timer_d     = HOLD_LOAD;
               alarm_d     = 1'b0;
               pulse_start = 1'b1;
            end
         end
         ST_CLOSE_HOLD: begin
            // Something back on the loop restarts the hold; it is not a
            // new entry, so no pulse.
            if (passed_rise) begin
               timer_d = HOLD_LOAD;
            end else if (timer_q == '0) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Outputs are registered from the next state, so they always equal the
   // decode of state_q without any combinational path from the inputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= ST_IDLE;
         timer_q        <= '0;
         alarm_q        <= 1'b0;
         barrier_open_q <= 1'b0;
         full_lamp_q    <= 1'b0;
         pulse_cnt_q    <= '0;
         entry_pulse_q  <= 1'b0;
      end else begin
         state_q        <= state_d;
         timer_q        <= timer_d;
         alarm_q        <= alarm_d;
         barrier_open_q <= (state_d == ST_OPEN) || (state_d == ST_PASSING) ||
                           (state_d == ST_CLOSE_HOLD);
         full_lamp_q    <= (state_d == ST_DENIED);

         // Pulse runs PULSE_LEN cycles regardless of later state changes.
         if (pulse_start) begin
            entry_pulse_q <= 1'b1;
            pulse_cnt_q   <= PULSE_LOAD;
         end else if (pulse_cnt_q != '0) begin
            pulse_cnt_q   <= pulse_cnt_q - PCW'(1);
         end else begin
            entry_pulse_q <= 1'b0;
         end
      end
   end

   assign barrier_open  = barrier_open_q;
   assign full_lamp     = full_lamp_q;
   assign entry_pulse   = entry_pulse_q;
   assign timeout_alarm = alarm_q;
   assign state_dbg     = state_q;

endmodule : entry_gate_ctrl

// File: tb/tb_entry_gate_ctrl.sv
// ---------------------------------------------------------------------------
// tb_entry_gate_ctrl
//   Scenario-driven bench for entry_gate_ctrl. Each scenario computes, from
//   the cycle at which it moves an input, when each output run (barrier_open,
//   full_lamp, entry_pulse) must start and how long it must last, and queues
//   that. A separate monitor measures every run the DUT actually produces
//   and compares it against the head of the matching queue.
//   Timing rule used throughout: an input changed just after edge t is acted
//   on by the FSM at edge t+3 (two sync flops plus the edge-detect stage).
// ---------------------------------------------------------------------------
module tb_entry_gate_ctrl;

   localparam int OT = 20;
   localparam int CH = 8;
   localparam int DC = 6;
   localparam int PL = 4;
   localparam int LAT = 3;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       car_present = 1'b0;
   logic       car_passed = 1'b0;
   logic       ticket_req = 1'b0;
   logic       space_avail = 1'b0;
   logic       barrier_open;
   logic       entry_pulse;
   logic       full_lamp;
   logic       timeout_alarm;
   logic [2:0] state_dbg;

   entry_gate_ctrl #(
      .OPEN_TIMEOUT (OT),
      .CLOSE_HOLD   (CH),
      .DENY_CYCLES  (DC),
      .PULSE_LEN    (PL)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .car_present   (car_present),
      .car_passed    (car_passed),
      .ticket_req    (ticket_req),
      .space_avail   (space_avail),
      .barrier_open  (barrier_open),
      .entry_pulse   (entry_pulse),
      .full_lamp     (full_lamp),
      .timeout_alarm (timeout_alarm),
      .state_dbg     (state_dbg)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int start;
      int len;
   } run_t;

   run_t exp_open_q[$];
   run_t exp_lamp_q[$];
   run_t exp_pulse_q[$];

   int n_checks = 0;
   int n_errors = 0;
   logic model_alarm = 1'b0;

   function automatic run_t mk(input int start, input int len);
      run_t r;
      r.start = start;
      r.len   = len;
      return r;
   endfunction

   task automatic check(input string name, input logic [31:0] got,
                        input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   // ---------------- monitor ----------------
   logic  prev_v [3] = '{1'b0, 1'b0, 1'b0};
   int    run_start [3] = '{0, 0, 0};
   string nm [3] = '{"barrier_open", "full_lamp", "entry_pulse"};

   task automatic track(input int k, input logic v);
      run_t e;
      bit   have;
      have = 1'b0;
      if (v === 1'b1 && prev_v[k] !== 1'b1) begin
         run_start[k] = cyc;
      end else if (v !== 1'b1 && prev_v[k] === 1'b1) begin
         case (k)
            0: if (exp_open_q.size() > 0)  begin e = exp_open_q.pop_front();  have = 1'b1; end
            1: if (exp_lamp_q.size() > 0)  begin e = exp_lamp_q.pop_front();  have = 1'b1; end
            default: if (exp_pulse_q.size() > 0) begin e = exp_pulse_q.pop_front(); have = 1'b1; end
         endcase
         if (!have) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_%s: run start %0d len %0d, no run expected",
                     nm[k], run_start[k], cyc - run_start[k]);
         end else begin
            check({nm[k], "_start"}, run_start[k], e.start);
            check({nm[k], "_len"}, cyc - run_start[k], e.len);
         end
      end
      prev_v[k] = v;
   endtask

   always @(negedge clk) begin
      track(0, barrier_open);
      track(1, full_lamp);
      track(2, entry_pulse);
   end

   // ---------------- stimulus helpers ----------------
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic step_to(input int target);
      while (cyc < target) step(1);
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 60 && state_dbg != 3'd0; i++) step(1);
      check("idle_before_scenario", state_dbg, 0);
      step(2);
   endtask

   task automatic open_gate(output int t1);
      space_avail = 1'b1;
      car_present = 1'b1;
      step($urandom_range(4, 8));
      ticket_req = 1'b1;
      t1 = cyc;
      step(2);
      ticket_req = 1'b0;
   endtask

   // Normal entry, optionally with a second object on the pass loop
   // during the hold.
   task automatic scen_entry(input bit tailgate);
      int t1, t3, t4, end_t;
      wait_idle();
      open_gate(t1);
      step($urandom_range(1, 10));
      car_passed = 1'b1;
      step($urandom_range(2, 6));
      check("alarm_sticky_before_entry", timeout_alarm, model_alarm);
      car_passed  = 1'b0;
      car_present = 1'b0;
      t3 = cyc;
      exp_pulse_q.push_back(mk(t3 + LAT, PL));
      end_t = t3 + LAT + CH;
      if (tailgate) begin
         step($urandom_range(2, 6));
         car_passed = 1'b1;
         t4 = cyc;
         step(3);
         car_passed = 1'b0;
         end_t = t4 + LAT + CH;
      end
      exp_open_q.push_back(mk(t1 + LAT, end_t - (t1 + LAT)));
      model_alarm = 1'b0;
      step_to(end_t + 2);
      check("entry_state_end", state_dbg, 0);
      check("entry_alarm_end", timeout_alarm, model_alarm);
   endtask

   task automatic scen_lot_full();
      int t1, tc;
      wait_idle();
      space_avail = 1'b0;
      car_present = 1'b1;
      step($urandom_range(4, 8));
      ticket_req = 1'b1;
      t1 = cyc;
      exp_lamp_q.push_back(mk(t1 + LAT, DC));
      step(2);
      ticket_req = 1'b0;
      step(1);
      ticket_req = 1'b1;   // second press while denied: ignored
      step(1);
      ticket_req = 1'b0;
      step_to(t1 + LAT + DC + 1);
      check("full_back_to_wait", state_dbg, 1);
      check("full_barrier_closed", barrier_open, 0);
      car_present = 1'b0;
      tc = cyc;
      step_to(tc + LAT + 1);
      check("full_car_left", state_dbg, 0);
      space_avail = 1'b1;
   endtask

   task automatic scen_timeout();
      int t1;
      wait_idle();
      open_gate(t1);
      car_present = 1'b0;
      exp_open_q.push_back(mk(t1 + LAT, OT + CH));
      step_to(t1 + LAT + OT - 1);
      check("alarm_before_timeout", timeout_alarm, model_alarm);
      step_to(t1 + LAT + OT + 1);
      model_alarm = 1'b1;
      check("alarm_after_timeout", timeout_alarm, model_alarm);
      check("timeout_in_hold", state_dbg, 4);
      step_to(t1 + LAT + OT + CH + 2);
      check("timeout_state_end", state_dbg, 0);
   endtask

   task automatic scen_balk();
      int t1;
      wait_idle();
      car_present = 1'b1;
      step($urandom_range(4, 8));
      check("balk_waiting", state_dbg, 1);
      ticket_req  = 1'b1;
      car_present = 1'b0;
      t1 = cyc;
      step(2);
      ticket_req = 1'b0;
      step_to(t1 + LAT + 3);
      check("balk_state", state_dbg, 0);
      check("balk_barrier", barrier_open, 0);
   endtask

   task automatic scen_reset_passing();
      int t1, tr;
      wait_idle();
      open_gate(t1);
      step($urandom_range(1, 10));
      car_passed = 1'b1;
      step($urandom_range(4, 6));
      check("rst_in_passing", state_dbg, 3);
      reset = 1'b1;
      tr = cyc;
      exp_open_q.push_back(mk(t1 + LAT, tr + 1 - (t1 + LAT)));
      step(1);
      model_alarm = 1'b0;
      check("rst_barrier", barrier_open, 0);
      check("rst_pulse", entry_pulse, 0);
      check("rst_lamp", full_lamp, 0);
      check("rst_alarm", timeout_alarm, model_alarm);
      check("rst_state", state_dbg, 0);
      reset       = 1'b0;
      car_passed  = 1'b0;
      car_present = 1'b0;
      step(12);
      check("rst_state_after", state_dbg, 0);
   endtask

   // ---------------- main ----------------
   initial begin
      reset = 1'b1;
      step(4);
      check("reset_barrier", barrier_open, 0);
      check("reset_pulse", entry_pulse, 0);
      check("reset_lamp", full_lamp, 0);
      check("reset_alarm", timeout_alarm, 0);
      check("reset_state", state_dbg, 0);
      reset = 1'b0;
      step(2);

      scen_entry(1'b0);
      scen_lot_full();
      scen_timeout();
      scen_entry(1'b0);
      scen_entry(1'b1);
      scen_balk();
      scen_reset_passing();

      for (int i = 0; i < 20; i++) begin
         case ($urandom_range(0, 5))
            0:       scen_entry(1'b0);
            1:       scen_entry(1'b1);
            2:       scen_lot_full();
            3:       scen_timeout();
            4:       scen_balk();
            default: scen_reset_passing();
         endcase
      end

      step(5);
      check("open_runs_left", exp_open_q.size(), 0);
      check("lamp_runs_left", exp_lamp_q.size(), 0);
      check("pulse_runs_left", exp_pulse_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1, "watchdog expired");
   end

endmodule : tb_entry_gate_ctrl
